// File: rtl/mult_operand_sequencer.sv
// Operand sequencer for a multi-cycle signed multiplier: latches a pair, strobes a load,
// waits LATENCY cycles, captures the product and holds it until downstream accepts.
// Optional macro SEQ_ZERO_BYPASS_EN: a zero operand completes immediately with out_p = 0.
module mult_operand_sequencer #(
    parameter int unsigned N       = 32,
    parameter int unsigned LATENCY = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_m,
    input  logic [N-1:0]   in_q,
    output logic [N-1:0]   mult_m,
    output logic [N-1:0]   mult_q,
    output logic           mult_ld,
    input  logic [2*N-1:0] mult_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p,
    output logic           busy
);

    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          accept_c;
    logic          capture_c;

`ifdef SEQ_ZERO_BYPASS_EN
    logic zero_c;
    assign zero_c = (in_m == '0) || (in_q == '0);
`endif

    // Next-state and counter logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept_c   = 1'b0;
        capture_c  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
`ifdef SEQ_ZERO_BYPASS_EN
                    state_next = zero_c ? DONE : LOAD;
`else
                    state_next = LOAD;
`endif
                end
            end
            LOAD: begin
                cnt_next   = CW'(LATENCY - 1);
                state_next = RUN;
            end
            RUN: begin
                if (cnt == '0) begin
                    capture_c  = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered outputs, all derived from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mult_m    <= '0;
            mult_q    <= '0;
            mult_ld   <= 1'b0;
            out_p     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            mult_ld   <= (state_next == LOAD);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
            in_ready  <= (state_next == IDLE);
            if (accept_c) begin
                mult_m <= in_m;
                mult_q <= in_q;
            end
            if (capture_c) begin
                out_p <= mult_p;
            end
`ifdef SEQ_ZERO_BYPASS_EN
            else if (accept_c && zero_c) begin
                out_p <= '0;
            end
`endif
        end
    end

endmodule

// File: doc/mult_operand_sequencer.md
MULT_OPERAND_SEQUENCER -- requirements
Module: mult_operand_sequencer

Interface
REQ-001 SHALL have parameter N, default 32: operand width in bits.
REQ-002 SHALL have parameter LATENCY, default 32: number of multiplier clock cycles needed to produce a valid product after load.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream operand pair valid.
REQ-006 SHALL have port in_ready, output, 1 bit: sequencer can accept an operand pair.
REQ-007 SHALL have port in_m, input, N bits: signed multiplicand.
REQ-008 SHALL have port in_q, input, N bits: signed multiplier.
REQ-009 SHALL have port mult_m, output, N bits: registered multiplicand driven to the multiplier.
REQ-010 SHALL have port mult_q, output, N bits: registered multiplier driven to the multiplier.
REQ-011 SHALL have port mult_ld, output, 1 bit: one-cycle load/restart strobe to the multiplier.
REQ-012 SHALL have port mult_p, input, 2N bits: signed product from the multiplier.
REQ-013 SHALL have port out_valid, output, 1 bit: out_p holds a completed product.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts out_p.
REQ-015 SHALL have port out_p, output, 2N bits: captured signed product.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement four states: IDLE, LOAD, RUN, DONE.
REQ-018 SHALL drive in_ready high only in IDLE.
REQ-019 SHALL, in IDLE with in_valid=1, register in_m/in_q into mult_m/mult_q and enter LOAD on the next edge (accept cycle = cycle 0).
REQ-020 SHALL hold mult_ld=1 for exactly the single LOAD cycle (cycle 1), load the cycle counter with LATENCY-1, and enter RUN.
REQ-021 SHALL decrement the counter once per cycle in RUN and, in the cycle the counter equals 0, capture mult_p into out_p and enter DONE; out_valid is first high in cycle LATENCY+2.
REQ-022 SHALL hold mult_m, mult_q stable from cycle 1 until the next accept.
REQ-023 SHALL keep out_valid=1 and out_p unchanged in DONE until out_ready=1; on that cycle's edge go to IDLE and clear out_valid.
REQ-024 SHALL not accept a new pair in the same cycle out_ready completes a transfer (one idle cycle minimum between transactions).
REQ-025 SHALL ignore in_m/in_q/in_valid changes while busy=1.
REQ-026 SHALL size the counter to ceil(log2(LATENCY)) bits, minimum 1; LATENCY=1 makes RUN last one cycle.
REQ-027 SHALL treat out_p as the raw 2N-bit two's-complement value of mult_p with no truncation or sign modification.

Reset
REQ-028 SHALL, when rst=0 at a rising edge, force state IDLE, counter 0, mult_m=0, mult_q=0, mult_ld=0, out_p=0, out_valid=0, busy=0; in_ready=1 after release.
REQ-029 SHALL abort any transaction in LOAD, RUN or DONE on reset, discarding it without asserting out_valid.

Configuration
REQ-030 SHALL provide macro SEQ_ZERO_BYPASS_EN.
REQ-031 SHALL, with SEQ_ZERO_BYPASS_EN defined, on an accept where in_m==0 or in_q==0, skip LOAD/RUN, not pulse mult_ld, set out_p=0, enter DONE, out_valid high in cycle 1.
REQ-032 SHALL, without SEQ_ZERO_BYPASS_EN, process zero operands through LOAD/RUN like any other pair.

Verification
REQ-033 SHALL test: in_m=7, in_q=2, mult_p model, LATENCY=32, out_ready=1 -> mult_ld single pulse in cycle 1, out_valid in cycle 34, out_p=14.
REQ-034 SHALL test: in_m=-7, in_q=3, out_ready=0 for 10 cycles after out_valid -> out_p=-21 (64'hFFFF_FFFF_FFFF_FFEB) held stable, in_ready=0 throughout.
REQ-035 SHALL test: in_m=0, in_q=-60 -> with SEQ_ZERO_BYPASS_EN out_valid in cycle 1, out_p=0, no mult_ld; without it out_valid in cycle 34, out_p=0.
REQ-036 SHALL test: in_m=20, in_q=-10, rst=0 asserted in cycle 10 -> all outputs at reset values next cycle, no out_valid; following pair -2*-2 -> out_p=4.
REQ-037 SHALL test: back-to-back in_valid=1 held with pairs (-19,3) then (2,-125) -> out_p=-57 then -250, second accept no earlier than one cycle after first out_valid/out_ready handshake.
